// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - NxN output-stationary systolic matrix multiplier with controller
// Takes one unskewed k-step per beat, skews it internally, drains the array, then emits C row by row.
module systolic_mm_engine #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int K_MAX  = 16,
  parameter int SIGNED = 1,
  parameter int ACC_W  = 2*DATA_W+$clog2(K_MAX),
  localparam int KW    = $clog2(K_MAX+1),
  localparam int RW    = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a [N],
  input  logic [DATA_W-1:0] in_b [N],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_row [N],
  output logic [RW-1:0]     out_row_idx,
  output logic              busy,
  output logic              done
);

  localparam int DCW = $clog2(2*N);
  localparam logic [KW-1:0]  K_MAX_V    = KW'(K_MAX);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2*N-2);
  localparam logic [RW-1:0]  ROW_LAST   = RW'(N-1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUT} state_t;
  state_t state, state_n;

  logic [KW-1:0]  k_reg, beat_cnt, k_clamped;
  logic [DCW-1:0] drain_cnt;
  logic [RW-1:0]  row_cnt;
  logic           done_q;
  logic           accept, en, clr, last_beat, drain_end, row_hs, last_row_hs;

  assign k_clamped   = (k_len > K_MAX_V) ? K_MAX_V : k_len;
  assign accept      = (state == S_LOAD) && in_valid;
  assign en          = accept || (state == S_DRAIN);
  assign clr         = (state == S_IDLE) && start;
  assign last_beat   = accept && (beat_cnt == (k_reg - KW'(1)));
  assign drain_end   = (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);
  assign row_hs      = (state == S_OUT) && out_ready;
  assign last_row_hs = row_hs && (row_cnt == ROW_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start)       state_n = (k_clamped == '0) ? S_OUT : S_LOAD;
      S_LOAD:  if (last_beat)   state_n = S_DRAIN;
      S_DRAIN: if (drain_end)   state_n = S_OUT;
      S_OUT:   if (last_row_hs) state_n = S_IDLE;
      default:                  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_reg     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      row_cnt   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= last_row_hs;
      if (clr) begin
        k_reg     <= k_clamped;
        beat_cnt  <= '0;
        drain_cnt <= '0;
        row_cnt   <= '0;
      end else begin
        if (accept)             beat_cnt  <= beat_cnt + KW'(1);
        if (state == S_DRAIN)   drain_cnt <= drain_cnt + DCW'(1);
        if (row_hs)             row_cnt   <= row_cnt + RW'(1);
      end
    end
  end

  assign in_ready    = (state == S_LOAD);
  assign out_valid   = (state == S_OUT);
  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign out_row_idx = out_valid ? row_cnt : '0;

  // Lanes carry zeros outside LOAD so DRAIN pushes bubbles through the array.
  logic [DATA_W-1:0] feed_a [N];
  logic [DATA_W-1:0] feed_b [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      feed_a[i] = (state == S_LOAD) ? in_a[i] : '0;
      feed_b[i] = (state == S_LOAD) ? in_b[i] : '0;
    end
  end

  // a_h[i][j] / b_h[i][j] are the operands presented to PE(i,j).
  logic [DATA_W-1:0] a_h   [N][N];
  logic [DATA_W-1:0] b_h   [N][N];
  logic [ACC_W-1:0]  acc_h [N][N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_h[0][0] = feed_a[0];
      assign b_h[0][0] = feed_b[0];
    end else begin : g_delay
      logic [DATA_W-1:0] da [i];
      logic [DATA_W-1:0] db [i];
      always_ff @(posedge clk or posedge reset) begin
        if (reset || clr) begin
          for (int d = 0; d < i; d++) begin
            da[d] <= '0;
            db[d] <= '0;
          end
        end else if (en) begin
          da[0] <= feed_a[i];
          db[0] <= feed_b[i];
          for (int d = 1; d < i; d++) begin
            da[d] <= da[d-1];
            db[d] <= db[d-1];
          end
        end
      end
      assign a_h[i][0] = da[i-1];
      assign b_h[0][i] = db[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [ACC_W-1:0] prod, acc;
      if (SIGNED != 0) begin : g_mul
        assign prod = ACC_W'($signed(a_h[i][j])) * ACC_W'($signed(b_h[i][j]));
      end else begin : g_mul
        assign prod = ACC_W'(a_h[i][j]) * ACC_W'(b_h[i][j]);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset || clr) acc <= '0;
        else if (en)      acc <= acc + prod;
      end
      assign acc_h[i][j] = acc;

      if (j < N-1) begin : g_fwd_a
        logic [DATA_W-1:0] a_r;
        always_ff @(posedge clk or posedge reset) begin
          if (reset || clr) a_r <= '0;
          else if (en)      a_r <= a_h[i][j];
        end
        assign a_h[i][j+1] = a_r;
      end

      if (i < N-1) begin : g_fwd_b
        logic [DATA_W-1:0] b_r;
        always_ff @(posedge clk or posedge reset) begin
          if (reset || clr) b_r <= '0;
          else if (en)      b_r <= b_h[i][j];
        end
        assign b_h[i+1][j] = b_r;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) out_row[j] = out_valid ? acc_h[row_cnt][j] : '0;
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb/tb_systolic_mm_engine.sv - scoreboard bench for systolic_mm_engine
// Signed and unsigned instances share stimulus; expected rows come from a plain sum-of-products model.
module tb_systolic_mm_engine;
  localparam int N = 4, DATA_W = 8, K_MAX = 16, KW = 5, RW = 2, ACC_W = 20;
  localparam int RV = RW + N*ACC_W;

  typedef struct packed {
    logic [RW-1:0]      idx;
    logic [N*ACC_W-1:0] data;
  } row_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [KW-1:0]     k_len = '0;
  logic [DATA_W-1:0] in_a [N];
  logic [DATA_W-1:0] in_b [N];
  logic in_ready_s, out_valid_s, busy_s, done_s;
  logic in_ready_u, out_valid_u, busy_u, done_u;
  logic [ACC_W-1:0] row_s [N];
  logic [ACC_W-1:0] row_u [N];
  logic [RW-1:0]    idx_s, idx_u;

  systolic_mm_engine #(.N(N), .DATA_W(DATA_W), .K_MAX(K_MAX), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready_s), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_row(row_s), .out_row_idx(idx_s), .busy(busy_s), .done(done_s));

  systolic_mm_engine #(.N(N), .DATA_W(DATA_W), .K_MAX(K_MAX), .SIGNED(0)) u_dut_u (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready_u), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_row(row_u), .out_row_idx(idx_u), .busy(busy_u), .done(done_u));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, viol = 0, jobs = 0, done_total = 0, in_ready_cycles = 0;
  int last_beat_cyc = 0, first_ov_cyc = 0, last_row_hs_cyc = -10;
  bit prev_ov = 0, stalled_prev = 0;
  logic [RV-1:0] held;
  logic [N*ACC_W-1:0] cur_s, cur_u;
  row_t q_s[$], q_u[$];
  row_t e_s, e_u;
  int ga [N][K_MAX];
  int gb [K_MAX][N];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int j = 0; j < N; j++) begin
      cur_s[j*ACC_W +: ACC_W] = row_s[j];
      cur_u[j*ACC_W +: ACC_W] = row_u[j];
    end
    if (reset) begin
      stalled_prev = 0;
      prev_ov = 0;
    end else begin
      if (in_ready_s) in_ready_cycles++;
      if (in_ready_s && (out_valid_s || !busy_s)) viol++;
      if (out_valid_s != out_valid_u || done_s != done_u || in_ready_s != in_ready_u) viol++;
      if (in_valid && in_ready_s) last_beat_cyc = cyc;
      if (out_valid_s && !prev_ov) first_ov_cyc = cyc;
      prev_ov = out_valid_s;
      if (stalled_prev) chk("hold_row", {out_valid_s, idx_s, cur_s}, {1'b1, held});
      stalled_prev = out_valid_s && !out_ready;
      held = {idx_s, cur_s};
      if (out_valid_s && out_ready) begin
        if (q_s.size() == 0) chk("row_s_extra", 1, 0);
        else begin
          e_s = q_s.pop_front();
          chk("row_signed", {idx_s, cur_s}, e_s);
        end
        if (q_u.size() == 0) chk("row_u_extra", 1, 0);
        else begin
          e_u = q_u.pop_front();
          chk("row_unsigned", {idx_u, cur_u}, e_u);
        end
        if (idx_s == RW'(N-1)) last_row_hs_cyc = cyc;
      end
      if (done_s) begin
        done_total++;
        chk("done_timing", cyc, last_row_hs_cyc + 1);
      end
    end
  end

  function automatic longint sx(input int v);
    return (v >= 128) ? longint'(v - 256) : longint'(v);
  endfunction

  task automatic push_expected(input int k);
    row_t es, eu;
    longint ss, su;
    for (int i = 0; i < N; i++) begin
      es.idx = RW'(i);
      eu.idx = RW'(i);
      for (int j = 0; j < N; j++) begin
        ss = 0;
        su = 0;
        for (int kk = 0; kk < k; kk++) begin
          ss += sx(ga[i][kk]) * sx(gb[kk][j]);
          su += longint'(ga[i][kk]) * longint'(gb[kk][j]);
        end
        es.data[j*ACC_W +: ACC_W] = ss[ACC_W-1:0];
        eu.data[j*ACC_W +: ACC_W] = su[ACC_W-1:0];
      end
      q_s.push_back(es);
      q_u.push_back(eu);
    end
  endtask

  task automatic fill_identity();
    for (int k = 0; k < K_MAX; k++)
      for (int i = 0; i < N; i++) begin
        ga[i][k] = (i == k) ? 1 : 0;
        gb[k][i] = 16*k + i;
      end
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < K_MAX; k++)
      for (int i = 0; i < N; i++) begin
        ga[i][k] = v;
        gb[k][i] = v;
      end
  endtask

  task automatic fill_random();
    for (int k = 0; k < K_MAX; k++)
      for (int i = 0; i < N; i++) begin
        ga[i][k] = int'($urandom_range(0, 255));
        gb[k][i] = int'($urandom_range(0, 255));
      end
  endtask

  // Called at posedge+1; returns at posedge+1 of the done cycle so the next job can chain.
  task automatic run_job(input int k_in, input int vmode, input int omode, input bit drain_start);
    int k_eff, sent, guard, ir0, stall_used;
    bit take;
    k_eff = (k_in > K_MAX) ? K_MAX : k_in;
    push_expected(k_eff);
    jobs++;
    ir0 = in_ready_cycles;
    start = 1'b1;
    k_len = KW'(k_in);
    @(posedge clk); #1;
    start = 1'b0;
    k_len = KW'($urandom_range(0, 31));
    if (k_eff > 0) chk("start_to_ready", in_ready_s, 1);
    sent = 0;
    guard = 0;
    while (sent < k_eff && guard < 2000) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (guard % 3 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      for (int i = 0; i < N; i++) begin
        in_a[i] = in_valid ? DATA_W'(ga[i][sent]) : DATA_W'($urandom);
        in_b[i] = in_valid ? DATA_W'(gb[sent][i]) : DATA_W'($urandom);
      end
      take = in_valid && in_ready_s;
      @(posedge clk); #1;
      if (take) sent++;
      guard++;
    end
    chk("beats_accepted", sent, k_eff);
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_a[i] = DATA_W'($urandom);
      in_b[i] = DATA_W'($urandom);
    end
    if (drain_start) begin
      start = 1'b1;
      k_len = KW'(3);
      @(posedge clk); #1;
      start = 1'b0;
    end
    guard = 0;
    stall_used = 0;
    while (!done_s && guard < 400) begin
      case (omode)
        0: out_ready = 1'b1;
        1: begin
          if (out_valid_s && idx_s == RW'(1) && stall_used < 3) begin
            out_ready = 1'b0;
            stall_used++;
          end else out_ready = 1'b1;
        end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
    chk("done_seen", done_s, 1);
    if (omode == 1) chk("stall_cycles", stall_used, 3);
    if (k_eff == 0) chk("k0_no_in_ready", in_ready_cycles - ir0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int i = 0; i < N; i++) begin
      in_a[i] = '0;
      in_b[i] = '0;
    end
    repeat (3) @(posedge clk); #1;
    for (int j = 0; j < N; j++) cur_s[j*ACC_W +: ACC_W] = row_s[j];
    chk("reset_outputs", {out_valid_s, in_ready_s, busy_s, done_s, idx_s, cur_s}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    fill_identity();
    run_job(4, 0, 0, 0);
    chk("last_beat_to_out_valid", first_ov_cyc - last_beat_cyc, 2*N);

    fill_const(255);
    run_job(16, 0, 0, 0);

    fill_identity();
    run_job(4, 1, 0, 0);

    run_job(4, 0, 1, 0);

    run_job(0, 0, 0, 0);
    fill_random();
    run_job(2, 0, 0, 0);

    fill_identity();
    start = 1'b1;
    k_len = KW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) begin
        in_a[i] = DATA_W'(ga[i][b]);
        in_b[i] = DATA_W'(gb[b][i]);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    d0 = done_total;
    reset = 1'b1;
    #1;
    for (int j = 0; j < N; j++) cur_s[j*ACC_W +: ACC_W] = row_s[j];
    chk("midjob_reset_outputs", {out_valid_s, in_ready_s, busy_s, done_s, idx_s, cur_s}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("midjob_reset_no_done", done_total - d0, 0);
    chk("midjob_reset_idle", busy_s, 0);
    run_job(4, 0, 0, 1);

    for (int t = 0; t < 12; t++) begin
      fill_random();
      run_job(int'($urandom_range(0, 20)), 2, 2, 0);
    end

    repeat (4) @(posedge clk); #1;
    chk("queue_s_empty", q_s.size(), 0);
    chk("queue_u_empty", q_u.size(), 0);
    chk("done_once_per_job", done_total, jobs);
    chk("protocol_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
